tlp_req_splitter: RTL
=====================

// Module: tlp_req_splitter
// PURPOSE
//  Upstream of the TLP byte-enable checker. Accepts one byte-granular memory request
//  (address, byte count, read/write) per handshake. Emits a sequence of TLP header fields
//  (addr, length DW, first/last BE, QW-aligned), one per output handshake.
//  Splits the request so no TLP exceeds the payload limit or crosses an MPS/MRRS-aligned
//  boundary, and therefore never crosses a 4 KB boundary.
// PARAMETERS
//  ADDR_W       64    request/TLP address width
//  MPS_BYTES    256   max payload for writes; power of two, 128..4096
//  MRRS_BYTES   512   max read request size; power of two, 128..4096
// PORTS
//  clk             in   1       clock
//  rst             in   1       asynchronous, active-high reset
//  req_valid       in   1       request valid
//  req_ready       out  1       request accepted when valid&ready
//  req_addr        in   ADDR_W  start byte address
//  req_bytes       in   13      byte count, 0..4096; >4096 is illegal input
//  req_is_write    in   1       1=MWr, 0=MRd
//  tlp_valid       out  1       TLP fields valid
//  tlp_ready       in   1       downstream accepts
//  tlp_addr        out  ADDR_W  TLP address, DW-aligned ([1:0]=0)
//  tlp_length      out  10      length in DW; 1024 encoded as 10'h000
//  tlp_first_be    out  4       first DW BE
//  tlp_last_be     out  4       last DW BE
//  tlp_is_write    out  1       copy of req_is_write
//  tlp_qw_aligned  out  1       ~start_addr[2]
//  tlp_last        out  1       final TLP of current request
//  err_zero_read   out  1       1-cycle pulse: zero-byte read dropped
//  stat_req_cnt    out  32      requests accepted (see CONFIGURATION)
//  stat_tlp_cnt    out  32      TLPs emitted (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; tlp_valid=0; req_ready=1; all tlp_* fields 0.
//   - err_zero_read=0; stats=0; the in-flight request is discarded.
//  FSM IDLE:
//   - req_ready=1; tlp_valid=0.
//   - On req handshake with bytes>0 or a write: load cursor (addr, remaining), compute the
//     first chunk into the output registers, go to EMIT. tlp_valid rises the next cycle
//     (1-cycle latency).
//   - Zero-byte read: pulse err_zero_read the next cycle, stay in IDLE, emit no TLP.
//  FSM EMIT:
//   - req_ready=0.
//   - All tlp_* outputs are registered and held stable while tlp_valid & !tlp_ready.
//   - On a tlp handshake with tlp_last=1: go to IDLE, tlp_valid=0 the next cycle. There is
//     a one-cycle bubble before the next request can be accepted.
//   - On a tlp handshake otherwise: advance the cursor and load the next chunk in the same
//     edge. Back-to-back TLPs, 1 per cycle.
//  Chunk math (cursor addr a, remaining r, limit L = write ? MPS : MRRS):
//   - off = a[1:0]; chunk = min(r, L - a[log2(L)-1:0]); end = off + chunk - 1.
//   - length = (off + chunk + 3) >> 2, in 11-bit math, truncated to 10 bits.
//   - len==1: first_be = ((1<<chunk)-1) << off, within 4 bits; last_be = 0.
//   - len>1: first_be = 4'hF << off; last_be = 4'hF >> (3 - end[1:0]).
//   - tlp_addr = {a[ADDR_W-1:2], 2'b00}.
//   - tlp_last = (r == chunk).
//  Zero-byte write: one TLP, len=1, first_be=0, last_be=0, tlp_last=1.
//  rst asserted mid-EMIT: tlp_valid drops immediately; no further chunks are emitted.
// CONFIGURATION
//  TLP_SPLIT_STATS_EN defined:
//   - stat_req_cnt increments on each accepted request, including dropped zero-byte reads.
//   - stat_tlp_cnt increments on each tlp handshake.
//   - Both counters are 32-bit and wrap at 2^32-1 -> 0.
//  Not defined: counters are absent; stat_* ports are tied to 0.
// STRUCTURE
//  Package tlp_split_pkg holds:
//   - state enum {IDLE, EMIT};
//   - constants DW_BYTES=4 and BOUNDARY_4K=4096;
//   - BE mask functions.
//  Sub-module tlp_chunk_calc: combinational (a, r, is_write) -> chunk, length, first_be,
//  last_be, last. Shared by the IDLE-load and EMIT-advance paths.
// TESTING
//  1. Write 0x1000, 4 B -> 1 TLP: len=1, first_be=F, last_be=0, last=1, qw_aligned=1.
//  2. Write 0x0FFE, 8 B (MPS 256), two TLPs:
//     - addr 0x0FFC, len=1, first_be=4'b1100, last_be=0;
//     - addr 0x1000, len=2, first_be=F, last_be=4'b0011, last=1.
//  3. Read 0x0, 1024 B (MRRS 512) -> 2 back-to-back TLPs, len=128 each, addr 0x0/0x200,
//     BEs F/F, last only on the second.
//  4. Write 0 B -> len=1, first_be=0, last_be=0. Read 0 B -> err_zero_read pulse, no
//     tlp_valid, req_ready=1.
//  5. tlp_ready held low for 3 cycles during case 2 -> all tlp_* outputs stable; TLP order
//     preserved.
//  6. rst during the first TLP of case 3 -> tlp_valid=0 at once. The next request starts
//     clean; with TLP_SPLIT_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/tlp_split_pkg.sv
// Shared types, constants and byte-enable helpers for the TLP request splitter.
package tlp_split_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int unsigned DW_BYTES    = 4;
    localparam int unsigned BOUNDARY_4K = 4096;
    // Wide enough to hold a byte count of exactly BOUNDARY_4K.
    localparam int unsigned REQ_BYTES_W = $clog2(BOUNDARY_4K) + 1;

    // First BE of a TLP whose whole payload sits in a single DW.
    function automatic logic [3:0] be_first_single(input logic [1:0] off, input logic [2:0] n);
        logic [7:0] m;
        m = 8'((8'd1 << n) - 8'd1);
        return 4'(m << off);
    endfunction

    function automatic logic [3:0] be_first_multi(input logic [1:0] off);
        return 4'(4'hF << off);
    endfunction

    function automatic logic [3:0] be_last(input logic [1:0] end_lo);
        return 4'(4'hF >> (2'd3 - end_lo));
    endfunction

endpackage

// File: rtl/tlp_chunk_calc.sv
// Combinational chunk sizing: clips the remaining byte count at the next MPS/MRRS-aligned
// boundary and derives DW length and byte enables for that chunk.
module tlp_chunk_calc
    import tlp_split_pkg::*;
#(
    parameter int unsigned MPS_BYTES  = 256,
    parameter int unsigned MRRS_BYTES = 512
) (
    input  logic [REQ_BYTES_W-1:0] addr_lo,
    input  logic [REQ_BYTES_W-1:0] rem,
    input  logic                   is_write,
    output logic [REQ_BYTES_W-1:0] chunk,
    output logic [9:0]             length,
    output logic [3:0]             first_be,
    output logic [3:0]             last_be,
    output logic                   last
);

    localparam logic [REQ_BYTES_W-1:0] MPS_L  = REQ_BYTES_W'(MPS_BYTES);
    localparam logic [REQ_BYTES_W-1:0] MRRS_L = REQ_BYTES_W'(MRRS_BYTES);
    localparam int unsigned SPAN_W = REQ_BYTES_W + 1;

    logic [REQ_BYTES_W-1:0] limit;
    logic [REQ_BYTES_W-1:0] room;
    logic [1:0]             off;
    logic [1:0]             end_lo;
    logic [SPAN_W-1:0]      span;
    logic                   single_dw;

    always_comb begin
        limit     = is_write ? MPS_L : MRRS_L;
        room      = limit - (addr_lo & (limit - REQ_BYTES_W'(1)));
        chunk     = (rem < room) ? rem : room;
        off       = addr_lo[1:0];
        end_lo    = off + chunk[1:0] - 2'd1;
        span      = SPAN_W'(off) + SPAN_W'(chunk) + SPAN_W'(3);
        single_dw = (SPAN_W'(off) + SPAN_W'(chunk)) <= SPAN_W'(DW_BYTES);
        // A zero-byte chunk still occupies one DW with all BEs off.
        length    = (chunk == '0) ? 10'd1 : 10'(span >> 2);
        first_be  = single_dw ? be_first_single(off, chunk[2:0]) : be_first_multi(off);
        last_be   = single_dw ? 4'h0 : be_last(end_lo);
        last      = (rem == chunk);
    end

endmodule

// File: rtl/tlp_req_splitter.sv
// Splits byte-granular memory requests into MPS/MRRS-bounded TLP header fields.
// Optional TLP_SPLIT_STATS_EN adds request/TLP counters on stat_*.
module tlp_req_splitter
    import tlp_split_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned MPS_BYTES  = 256,
    parameter int unsigned MRRS_BYTES = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [REQ_BYTES_W-1:0] req_bytes,
    input  logic                   req_is_write,
    output logic                   tlp_valid,
    input  logic                   tlp_ready,
    output logic [ADDR_W-1:0]      tlp_addr,
    output logic [9:0]             tlp_length,
    output logic [3:0]             tlp_first_be,
    output logic [3:0]             tlp_last_be,
    output logic                   tlp_is_write,
    output logic                   tlp_qw_aligned,
    output logic                   tlp_last,
    output logic                   err_zero_read,
    output logic [31:0]            stat_req_cnt,
    output logic [31:0]            stat_tlp_cnt
);

    state_t                 state_q, state_d;
    logic                   load;
    logic                   zero_rd;
    logic                   req_fire;
    logic                   tlp_fire;

    logic [ADDR_W-1:0]      nxt_addr_q;
    logic [REQ_BYTES_W-1:0] nxt_rem_q;
    logic [ADDR_W-1:0]      cur_addr;
    logic [REQ_BYTES_W-1:0] cur_rem;
    logic                   cur_wr;

    logic [REQ_BYTES_W-1:0] c_chunk;
    logic [9:0]             c_length;
    logic [3:0]             c_first_be;
    logic [3:0]             c_last_be;
    logic                   c_last;

    assign req_fire = req_valid & req_ready;
    assign tlp_fire = tlp_valid & tlp_ready;

    // Calculator sees the new request when idle, otherwise the stored cursor.
    always_comb begin
        cur_addr = nxt_addr_q;
        cur_rem  = nxt_rem_q;
        cur_wr   = tlp_is_write;
        if (state_q == IDLE) begin
            cur_addr = req_addr;
            cur_rem  = req_bytes;
            cur_wr   = req_is_write;
        end
    end

    tlp_chunk_calc #(
        .MPS_BYTES  (MPS_BYTES),
        .MRRS_BYTES (MRRS_BYTES)
    ) u_calc (
        .addr_lo  (cur_addr[REQ_BYTES_W-1:0]),
        .rem      (cur_rem),
        .is_write (cur_wr),
        .chunk    (c_chunk),
        .length   (c_length),
        .first_be (c_first_be),
        .last_be  (c_last_be),
        .last     (c_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        zero_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    if (req_bytes == '0 && !req_is_write) begin
                        zero_rd = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (tlp_fire) begin
                    if (tlp_last) state_d = IDLE;
                    else          load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready      <= 1'b1;
            tlp_valid      <= 1'b0;
            err_zero_read  <= 1'b0;
            tlp_addr       <= '0;
            tlp_length     <= '0;
            tlp_first_be   <= '0;
            tlp_last_be    <= '0;
            tlp_is_write   <= 1'b0;
            tlp_qw_aligned <= 1'b0;
            tlp_last       <= 1'b0;
            nxt_addr_q     <= '0;
            nxt_rem_q      <= '0;
        end else begin
            req_ready     <= (state_d == IDLE);
            tlp_valid     <= (state_d == EMIT);
            err_zero_read <= zero_rd;
            if (load) begin
                tlp_addr       <= {cur_addr[ADDR_W-1:2], 2'b00};
                tlp_length     <= c_length;
                tlp_first_be   <= c_first_be;
                tlp_last_be    <= c_last_be;
                tlp_is_write   <= cur_wr;
                tlp_qw_aligned <= ~cur_addr[2];
                tlp_last       <= c_last;
                nxt_addr_q     <= cur_addr + ADDR_W'(c_chunk);
                nxt_rem_q      <= cur_rem - c_chunk;
            end
        end
    end

`ifdef TLP_SPLIT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_req_cnt <= '0;
            stat_tlp_cnt <= '0;
        end else begin
            if (req_fire) stat_req_cnt <= stat_req_cnt + 32'd1;
            if (tlp_fire) stat_tlp_cnt <= stat_tlp_cnt + 32'd1;
        end
    end
`else
    assign stat_req_cnt = '0;
    assign stat_tlp_cnt = '0;
`endif

endmodule
